// File: rtl/ifetch_if.sv
// ifetch_if: instruction-memory read bus between the fetch stage and imem.
// A request is held until acked; rdata is valid in the ack cycle.
interface ifetch_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          im_req;
  logic [AW-1:0] im_addr;
  logic          im_ack;
  logic [DW-1:0] im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_ack,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_ack,
    output im_rdata
  );
endinterface

// File: rtl/ifetch.sv
// ifetch: SISC fetch stage -- PC, imem req/ack and prefetch queue.
// Define IFETCH_PREFETCH_EN for a 2-deep queue (1-deep otherwise).
module ifetch #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_f,
  ifetch_if.master      im,
  output logic          fetch_valid,
  output logic [DW-1:0] read_data,
  output logic [AW-1:0] fetch_pc,
  input  logic          ir_load,
  input  logic          br_load,
  input  logic [AW-1:0] br_addr
);

`ifdef IFETCH_PREFETCH_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_n;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_n;
  logic [1:0]    count;
  logic [1:0]    count_n;
  logic [1:0]    wr_idx;
  logic          push;
  logic          pop;
  logic          free;

  logic [DW-1:0] q_data [D];
  logic [AW-1:0] q_pc   [D];
  logic [DW-1:0] qd_n   [D];
  logic [AW-1:0] qp_n   [D];

  assign push   = (state == REQ) && im.im_ack && !br_load;
  assign pop    = ir_load && fetch_valid && !br_load;
  assign wr_idx = count - {1'b0, pop};

  always_comb begin
    count_n = count + {1'b0, push} - {1'b0, pop};
    if (br_load) begin
      count_n = '0;
    end
  end

  assign free = count_n < 2'(D);

  always_comb begin
    pc_n = pc;
    if (br_load) begin
      pc_n = br_addr;
    end else if (push) begin
      pc_n = pc + ONE;
    end
  end

  // DROP keeps the squashed address on the bus until its ack retires it
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (free) begin
          state_n = REQ;
        end
      end
      REQ: begin
        if (im.im_ack) begin
          state_n = free ? REQ : IDLE;
        end else if (br_load) begin
          state_n = DROP;
        end
      end
      DROP: begin
        if (im.im_ack) begin
          state_n = free ? REQ : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    addr_n = addr;
    if (state_n == REQ) begin
      addr_n = pc_n;
    end
  end

  always_comb begin
    for (int i = 0; i < D; i++) begin
      qd_n[i] = q_data[i];
      qp_n[i] = q_pc[i];
    end
    if (pop) begin
      for (int i = 0; i < D - 1; i++) begin
        qd_n[i] = q_data[i+1];
        qp_n[i] = q_pc[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < D; i++) begin
        if (wr_idx == 2'(i)) begin
          qd_n[i] = im.im_rdata;
          qp_n[i] = pc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state <= IDLE;
      pc    <= '0;
      addr  <= '0;
      count <= '0;
      for (int i = 0; i < D; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      state <= state_n;
      pc    <= pc_n;
      addr  <= addr_n;
      count <= count_n;
      for (int i = 0; i < D; i++) begin
        q_data[i] <= qd_n[i];
        q_pc[i]   <= qp_n[i];
      end
    end
  end

  assign im.im_req   = (state != IDLE);
  assign im.im_addr  = addr;
  assign fetch_valid = (count != 2'd0);
  assign read_data   = q_data[0];
  assign fetch_pc    = q_pc[0];

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: fetch-stage bench with a memory model and a stream scoreboard.
// Expected queue depth follows IFETCH_PREFETCH_EN like the design.
`timescale 1ns/1ps
module tb_ifetch;
  localparam int AW = 16;
  localparam int DW = 32;
`ifdef IFETCH_PREFETCH_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_f = 1'b0;
  logic          ir_load = 1'b0;
  logic          br_load = 1'b0;
  logic [AW-1:0] br_addr = '0;
  logic          fetch_valid;
  logic [DW-1:0] read_data;
  logic [AW-1:0] fetch_pc;

  ifetch_if #(.AW(AW), .DW(DW)) bus ();

  ifetch #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .im         (bus.master),
    .fetch_valid(fetch_valid),
    .read_data  (read_data),
    .fetch_pc   (fetch_pc),
    .ir_load    (ir_load),
    .br_load    (br_load),
    .br_addr    (br_addr)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  int            lat_mode;
  int            lat_cur;
  int            wcnt;
  logic          prev_req;
  logic          prev_ack;
  logic [AW-1:0] prev_addr;

  int            occ;
  int            pops;
  logic          squash;
  logic [AW-1:0] exp_pc;
  logic [AW-1:0] nreq;
  logic [AW-1:0] pop_log [$];

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {16'hA000, a};
  endfunction

  function automatic int pick_lat();
    if (lat_mode < 0) return int'($urandom_range(0, 3));
    return lat_mode;
  endfunction

  // zero/fixed/random-latency memory; garbage on rdata when not acking
  task automatic mem_update();
    if (!bus.im_req) begin
      bus.im_ack = 1'b0;
      wcnt = 0;
      lat_cur = pick_lat();
    end else begin
      if (prev_req && !prev_ack) begin
        checks++;
        if (bus.im_addr !== prev_addr)
          $display("FAIL addr_hold: got %h want %h", bus.im_addr, prev_addr);
        if (bus.im_addr !== prev_addr) errs++;
      end
      if (prev_ack) begin
        wcnt = 0;
        lat_cur = pick_lat();
      end
      if (wcnt >= lat_cur) begin
        bus.im_ack = 1'b1;
      end else begin
        bus.im_ack = 1'b0;
        wcnt++;
      end
    end
    bus.im_rdata = bus.im_ack ? word(bus.im_addr) : DW'($urandom);
    prev_req  = bus.im_req;
    prev_ack  = bus.im_ack;
    prev_addr = bus.im_addr;
  endtask

  task automatic sb_check();
    checks++;
    if (fetch_valid !== (occ > 0)) begin
      errs++;
      $display("FAIL valid: got %b want %b", fetch_valid, occ > 0);
    end
    if (fetch_valid === 1'b1) begin
      checks++;
      if (fetch_pc !== exp_pc || read_data !== word(exp_pc)) begin
        errs++;
        $display("FAIL head: got %h/%h want %h/%h",
                 fetch_pc, read_data, exp_pc, word(exp_pc));
      end
    end
  endtask

  // one clock: account for the edge about to happen, then observe
  task automatic cycle();
    logic live;
    live = bus.im_req && bus.im_ack && !br_load && !squash;
    if (bus.im_req && bus.im_ack) begin
      if (live) begin
        checks++;
        if (bus.im_addr !== nreq) begin
          errs++;
          $display("FAIL req_addr: got %h want %h", bus.im_addr, nreq);
        end
        checks++;
        if (occ >= D) begin
          errs++;
          $display("FAIL push_full: got occ %0d want below %0d", occ, D);
        end
        nreq++;
      end
      squash = 1'b0;
    end
    if (ir_load && fetch_valid && !br_load) begin
      occ--;
      pops++;
      pop_log.push_back(fetch_pc);
      exp_pc++;
    end
    if (live) occ++;
    if (br_load) begin
      if (bus.im_req && !bus.im_ack) squash = 1'b1;
      occ = 0;
      exp_pc = br_addr;
      nreq = br_addr;
    end
    @(posedge clk);
    @(negedge clk);
    mem_update();
    sb_check();
  endtask

  task automatic do_reset(input int lat);
    rst_f = 1'b0;
    ir_load = 1'b0;
    br_load = 1'b0;
    bus.im_ack = 1'b0;
    repeat (2) @(negedge clk);
    lat_mode = lat;
    lat_cur = pick_lat();
    wcnt = 0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_addr = '0;
    occ = 0;
    pops = 0;
    squash = 1'b0;
    exp_pc = '0;
    nreq = '0;
    pop_log.delete();
    rst_f = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.im_req !== 1'b0 || bus.im_addr !== '0 || fetch_valid !== 1'b0 ||
        read_data !== '0 || fetch_pc !== '0) begin
      errs++;
      $display("FAIL reset_vals: got %b %h %b %h %h want 0 0 0 0 0",
               bus.im_req, bus.im_addr, fetch_valid, read_data, fetch_pc);
    end
    do_reset(0);
    checks++;
    if (bus.im_req !== 1'b0) begin
      errs++;
      $display("FAIL req_at_release: got %b want 0", bus.im_req);
    end
    cycle();
    checks++;
    if (bus.im_req !== 1'b1 || bus.im_addr !== '0) begin
      errs++;
      $display("FAIL first_req: got %b/%h want 1/0", bus.im_req, bus.im_addr);
    end
  endtask

  task automatic test_stream();
    int nv;
    do_reset(0);
    ir_load = 1'b1;
    cycle();
    checks++;
    if (fetch_valid !== 1'b0) begin
      errs++;
      $display("FAIL stream_c1: got %b want 0", fetch_valid);
    end
    cycle();
    checks++;
    if (fetch_valid !== 1'b1 || read_data !== 32'hA000_0000) begin
      errs++;
      $display("FAIL stream_c2: got %b/%h want 1/a0000000", fetch_valid, read_data);
    end
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      if (fetch_valid === 1'b1) nv++;
      cycle();
    end
    checks++;
    if (nv != ((D == 2) ? 20 : 10)) begin
      errs++;
      $display("FAIL throughput: got %0d want %0d", nv, (D == 2) ? 20 : 10);
    end
  endtask

  task automatic test_stall();
    do_reset(0);
    ir_load = 1'b0;
    repeat (10) cycle();
    checks++;
    if (bus.im_req !== 1'b0 || fetch_valid !== 1'b1 ||
        read_data !== 32'hA000_0000 || fetch_pc !== '0) begin
      errs++;
      $display("FAIL stall: got %b %b %h %h want 0 1 a0000000 0000",
               bus.im_req, fetch_valid, read_data, fetch_pc);
    end
  endtask

  task automatic test_delay();
    do_reset(3);
    ir_load = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      checks++;
      if (fetch_valid !== (k == 5)) begin
        errs++;
        $display("FAIL delay_valid: got %b want %b at %0d", fetch_valid, k == 5, k);
      end
      if (k < 5) begin
        checks++;
        if (bus.im_req !== 1'b1 || bus.im_addr !== '0) begin
          errs++;
          $display("FAIL delay_req: got %b/%h want 1/0", bus.im_req, bus.im_addr);
        end
      end
    end
  endtask

  task automatic test_branch_drop();
    int n;
    do_reset(3);
    ir_load = 1'b1;
    n = 0;
    while (!(bus.im_req && bus.im_addr == 16'h0005 && !bus.im_ack) && n < 200) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errs++;
      $display("FAIL drop_timeout: got %0d cycles want below 200", n);
    end
    br_load = 1'b1;
    br_addr = 16'h0040;
    cycle();
    br_load = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || bus.im_req !== 1'b1 || bus.im_addr !== 16'h0005) begin
      errs++;
      $display("FAIL drop_hold: got %b %b %h want 0 1 0005",
               fetch_valid, bus.im_req, bus.im_addr);
    end
    n = 1;
    while (fetch_valid !== 1'b1 && n < 50) begin
      cycle();
      n++;
    end
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 16'h0040 || n < 2) begin
      errs++;
      $display("FAIL drop_target: got %b/%h after %0d want 1/0040 after 2+",
               fetch_valid, fetch_pc, n);
    end
  endtask

  task automatic test_branch_full();
    do_reset(0);
    ir_load = 1'b0;
    repeat (10) cycle();
    br_load = 1'b1;
    ir_load = 1'b1;
    br_addr = 16'h1234;
    cycle();
    br_load = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || bus.im_req !== 1'b1 || bus.im_addr !== 16'h1234) begin
      errs++;
      $display("FAIL flush: got %b %b %h want 0 1 1234",
               fetch_valid, bus.im_req, bus.im_addr);
    end
    cycle();
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 16'h1234) begin
      errs++;
      $display("FAIL flush_target: got %b/%h want 1/1234", fetch_valid, fetch_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset(0);
    ir_load = 1'b1;
    br_load = 1'b1;
    br_addr = 16'hFFFF;
    cycle();
    br_load = 1'b0;
    pop_log.delete();
    repeat (8) cycle();
    checks++;
    if (pop_log.size() < 2) begin
      errs++;
      $display("FAIL wrap_pops: got %0d want 2+", pop_log.size());
    end else if (pop_log[0] !== 16'hFFFF || pop_log[1] !== 16'h0000) begin
      errs++;
      $display("FAIL wrap: got %h,%h want ffff,0000", pop_log[0], pop_log[1]);
    end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset(3);
    ir_load = 1'b1;
    n = 0;
    while (!(pops > 0 && bus.im_req && !bus.im_ack) && n < 100) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errs++;
      $display("FAIL arst_setup: got %0d cycles want below 100", n);
    end
    #2 rst_f = 1'b0;
    #1;
    checks++;
    if (bus.im_req !== 1'b0 || bus.im_addr !== '0 || fetch_valid !== 1'b0 ||
        read_data !== '0 || fetch_pc !== '0) begin
      errs++;
      $display("FAIL arst_vals: got %b %h %b %h %h want 0 0 0 0 0",
               bus.im_req, bus.im_addr, fetch_valid, read_data, fetch_pc);
    end
    do_reset(0);
    ir_load = 1'b1;
    n = 0;
    while (fetch_valid !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== '0) begin
      errs++;
      $display("FAIL arst_restart: got %b/%h want 1/0000", fetch_valid, fetch_pc);
    end
  endtask

  task automatic test_random();
    do_reset(-1);
    for (int i = 0; i < 3000; i++) begin
      ir_load = ($urandom_range(0, 3) != 0);
      br_load = ($urandom_range(0, 24) == 0);
      br_addr = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      cycle();
    end
    br_load = 1'b0;
    checks++;
    if (pops < 300) begin
      errs++;
      $display("FAIL random_progress: got %0d pops want 300+", pops);
    end
  endtask

  initial begin
    bus.im_ack = 1'b0;
    bus.im_rdata = '0;
    lat_mode = 0;
    test_reset();
    test_stream();
    test_stall();
    test_delay();
    test_branch_drop();
    test_branch_full();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
